regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised, clocked successor to the single-cycle CPU's two-read/one-write register file. It provides:
- Configurable data width, depth and read-port count.
- Synchronous byte-masked writes.
- Combinational reads with optional write-to-read bypass.
- Optional hardwired zero register.
- A sequenced clear engine.

It sits between decode and the ALU/writeback path. File-based init/dump is not used; contents come from reset and writes only.

Parameters:
DATA_WIDTH, 32, register width in bits; must be a multiple of 8
ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH
NUM_READ, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
BYPASS, 1, 1 = a read of the register being written this cycle returns the post-write value

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all registers and FSM
reg_write  input  1  write request
write_reg  input  ADDR_WIDTH  write index
write_data  input  DATA_WIDTH  write value
write_mask  input  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i]
write_accept  output  1  combinational; high when reg_write is taken this cycle
read_reg  input  NUM_READ*ADDR_WIDTH  packed read indices; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
read_data  output  NUM_READ*DATA_WIDTH  packed read data; port p at [p*DATA_WIDTH +: DATA_WIDTH]
clear_req  input  1  start a full-array clear
clear_busy  output  1  clear sequence in progress
clear_done  output  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (async, active-high): all DEPTH registers become 0; FSM goes to IDLE; clear index becomes 0; clear_busy=0; clear_done=0. Reads during reset return 0.
- write_accept = reg_write & (state==IDLE).
- Accepted write: on the rising edge, every byte with write_mask[i]=1 takes write_data's byte i; other bytes hold.
  - Mask all-zero: accepted, but no change.
  - With ZERO_REG=1, writes to index 0 are accepted and discarded.
- Reads are combinational; latency 0 relative to read_reg.
  - With ZERO_REG=1, index 0 always returns 0.
  - With BYPASS=1, when write_accept=1 and write_reg equals a port's index (and not zero-reg), that port returns the masked merge of the stored value and write_data. The merge is combinational and visible in the same cycle.
  - With BYPASS=0, that port returns the old stored value until after the edge.
  - All ports are independent; identical indices on several ports return identical data.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clear_req=1 -> CLEAR, with index=0.
  - CLEAR: each cycle, registers[index] is set to 0 and index increments. When index==DEPTH-1, that register is zeroed and the FSM goes to DONE. A full clear takes exactly DEPTH cycles in CLEAR.
  - DONE: clear_done=1 for this single cycle, then IDLE.
  - clear_busy=1 in CLEAR and DONE.
  - clear_req is ignored outside IDLE; a request held high re-triggers from IDLE after DONE.
- During CLEAR/DONE:
  - write_accept=0 and writes are dropped; the requester must hold reg_write.
  - Reads return current contents, i.e. partially cleared. Bypass is inactive because no write is accepted.
- Simultaneous reg_write and clear_req in IDLE: the write is accepted that cycle and the FSM enters CLEAR on the same edge. The written register is later zeroed by the sweep.
- Reset asserted mid-CLEAR aborts the sweep immediately: array is 0, FSM is IDLE, and no clear_done pulse.
- The index counter is ADDR_WIDTH wide; DONE is detected by compare, not by wrap. The index never wraps into a second sweep.

Test Plan:
- Reset then read all ports at indices 0..31 -> every read_data = 0x00000000; clear_busy=0.
- Write reg 5 = 0xDEADBEEF, mask 4'b1111; next cycle read port0=5, port1=5 -> both 0xDEADBEEF. Then write 0x11223344 with mask 4'b0101 -> reg 5 = 0xDE22BE44.
- BYPASS=1: reg 7 holds 0xAAAAAAAA; in one cycle write 7 = 0x55555555 with mask 4'b0011 while port1 reads 7 -> same-cycle read_data = 0xAAAA5555. Repeat with BYPASS=0 -> 0xAAAAAAAA, then 0xAAAA5555 after the edge.
- ZERO_REG=1: write reg 0 = 0xFFFFFFFF -> write_accept=1 and reg 0 still reads 0. ZERO_REG=0 -> reads 0xFFFFFFFF.
- Fill regs 1..31 with their index. Pulse clear_req -> clear_busy high for 33 cycles. clear_done pulses once on cycle 33. reg_write during the sweep gives write_accept=0. All regs read 0 afterwards.
- Start a clear, assert reset at sweep cycle 10 -> immediate IDLE, all zeros, no clear_done. After release, write reg 3 = 0x1 succeeds in the first cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with byte-masked writes, optional same-cycle write
// bypass, optional hardwired zero register and a one-register-per-cycle clear sweep.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           reg_write,
  input  logic [ADDR_WIDTH-1:0]          write_reg,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic [DATA_WIDTH/8-1:0]        write_mask,
  output logic                           write_accept,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_reg,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  input  logic                           clear_req,
  output logic                           clear_busy,
  output logic                           clear_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic                    r_busy;
  logic                    r_done;
  logic [DATA_WIDTH-1:0]   r_regs [DEPTH];

  logic                    w_accept;
  logic                    w_wr_en;
  logic [ADDR_WIDTH-1:0]   w_ridx [NUM_READ];
  logic [DATA_WIDTH-1:0]   w_rval [NUM_READ];

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [NB-1:0]         mask
  );
    merge_bytes = old_v;
    for (int i = 0; i < NB; i++) begin
      if (mask[i]) merge_bytes[8*i +: 8] = new_v[8*i +: 8];
    end
  endfunction

  assign w_accept     = reg_write && (r_state == S_IDLE);
  // Writes to the zero register are accepted on the handshake but never stored.
  assign w_wr_en      = w_accept && !((ZERO_REG != 0) && (write_reg == '0));
  assign write_accept = w_accept;
  assign clear_busy   = r_busy;
  assign clear_done   = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear_req) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          // Last index is caught by compare so the sweep can never wrap around.
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + ADDR_WIDTH'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_regs[r_idx] <= '0;
    end else if (w_wr_en) begin
      r_regs[write_reg] <= merge_bytes(r_regs[write_reg], write_data, write_mask);
    end
  end

  always_comb begin
    read_data = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      w_ridx[p] = read_reg[p*ADDR_WIDTH +: ADDR_WIDTH];
      w_rval[p] = r_regs[w_ridx[p]];
      if ((BYPASS != 0) && w_wr_en && (write_reg == w_ridx[p]))
        w_rval[p] = merge_bytes(r_regs[w_ridx[p]], write_data, write_mask);
      if (reset || ((ZERO_REG != 0) && (w_ridx[p] == '0)))
        w_rval[p] = '0;
      read_data[p*DATA_WIDTH +: DATA_WIDTH] = w_rval[p];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero-reg+bypass, and neither) share stimulus
// and are checked each cycle against an array model plus directed literal values.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic [9:0]  read_reg;
  logic        clear_req;

  logic        wa_a, busy_a, done_a;
  logic        wa_b, busy_b, done_b;
  logic [63:0] rd_a, rd_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] mA [32];
  logic [31:0] mB [32];
  int          sweep = -1;

  always #5 clk = ~clk;

  regfile_mp dut_a (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .write_mask(write_mask), .write_accept(wa_a),
    .read_reg(read_reg), .read_data(rd_a), .clear_req(clear_req),
    .clear_busy(busy_a), .clear_done(done_a)
  );

  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .write_mask(write_mask), .write_accept(wa_b),
    .read_reg(read_reg), .read_data(rd_b), .clear_req(clear_req),
    .clear_busy(busy_b), .clear_done(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] old_v, input logic [31:0] new_v,
                                      input logic [3:0] mask);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_a(input int idx);
    if (reset || idx == 0) return 32'h0;
    if (reg_write && sweep < 0 && int'(write_reg) == idx) return mrg(mA[idx], write_data, write_mask);
    return mA[idx];
  endfunction

  function automatic logic [31:0] exp_b(input int idx);
    if (reset) return 32'h0;
    return mB[idx];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      mA[i] = '0;
      mB[i] = '0;
    end
  end

  // Reference model: whole array cleared on reset, one cell zeroed per sweep cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mA[i] = '0;
        mB[i] = '0;
      end
      sweep = -1;
    end else if (sweep < 0) begin
      if (reg_write) begin
        if (write_reg != 0) mA[write_reg] = mrg(mA[write_reg], write_data, write_mask);
        mB[write_reg] = mrg(mB[write_reg], write_data, write_mask);
      end
      if (clear_req) sweep = 0;
    end else if (sweep < 32) begin
      mA[sweep] = '0;
      mB[sweep] = '0;
      sweep = sweep + 1;
    end else begin
      sweep = -1;
    end
  end

  always @(negedge clk) begin
    logic acc;
    acc = reg_write && (sweep < 0);
    for (int p = 0; p < 2; p++) begin
      check($sformatf("rdA_p%0d", p), rd_a[32*p +: 32], exp_a(int'(read_reg[5*p +: 5])));
      check($sformatf("rdB_p%0d", p), rd_b[32*p +: 32], exp_b(int'(read_reg[5*p +: 5])));
    end
    check("acceptA", {31'b0, wa_a}, {31'b0, acc});
    check("acceptB", {31'b0, wa_b}, {31'b0, acc});
    check("busyA", {31'b0, busy_a}, {31'b0, sweep >= 0});
    check("busyB", {31'b0, busy_b}, {31'b0, sweep >= 0});
    check("doneA", {31'b0, done_a}, {31'b0, sweep == 32});
    check("doneB", {31'b0, done_b}, {31'b0, sweep == 32});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rsel(input logic [4:0] p0, input logic [4:0] p1);
    read_reg = {p1, p0};
  endtask

  task automatic set_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
    write_mask = m;
  endtask

  initial begin
    int nb, nd, dcyc;
    logic saw_acc, done_in_rst;
    reset = 1'b1;
    reg_write = 1'b0; write_reg = '0; write_data = '0; write_mask = '0;
    read_reg = '0; clear_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy_a}, 32'h0);
    check("rst_rd", rd_a[31:0], 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rsel(5'(i), 5'(31 - i));
      step();
    end

    set_wr(5, 32'hDEADBEEF, 4'b1111);
    rsel(5, 5);
    step();
    reg_write = 1'b0;
    #1;
    check("wr5_p0", rd_a[31:0], 32'hDEADBEEF);
    check("wr5_p1", rd_a[63:32], 32'hDEADBEEF);
    set_wr(5, 32'h11223344, 4'b0101);
    step();
    reg_write = 1'b0;
    #1;
    check("mask5_A", rd_a[31:0], 32'hDE22BE44);
    check("mask5_B", rd_b[31:0], 32'hDE22BE44);

    set_wr(7, 32'hAAAAAAAA, 4'b1111);
    step();
    set_wr(7, 32'h55555555, 4'b0011);
    rsel(0, 7);
    #1;
    check("byp_A", rd_a[63:32], 32'hAAAA5555);
    check("nobyp_B", rd_b[63:32], 32'hAAAAAAAA);
    step();
    reg_write = 1'b0;
    #1;
    check("after_B", rd_b[63:32], 32'hAAAA5555);

    set_wr(0, 32'hFFFFFFFF, 4'b1111);
    rsel(0, 0);
    #1;
    check("z_acc", {31'b0, wa_a}, 32'h1);
    check("z_rdA_same", rd_a[31:0], 32'h0);
    step();
    reg_write = 1'b0;
    #1;
    check("z_rdA", rd_a[31:0], 32'h0);
    check("z_rdB", rd_b[31:0], 32'hFFFFFFFF);

    set_wr(5, 32'h0, 4'b0000);
    rsel(5, 5);
    step();
    reg_write = 1'b0;
    #1;
    check("mask0", rd_a[31:0], 32'hDE22BE44);

    for (int i = 1; i < 32; i++) begin
      set_wr(5'(i), 32'(i), 4'b1111);
      rsel(5'(i), 5'(i));
      step();
    end
    set_wr(9, 32'h99, 4'b1111);
    clear_req = 1'b1;
    #1;
    check("simul_acc", {31'b0, wa_a}, 32'h1);
    step();
    clear_req = 1'b0;
    set_wr(4, 32'h4444, 4'b1111);
    nb = 0; nd = 0; dcyc = 0; saw_acc = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy_a) nb++;
      if (done_a) begin
        nd++;
        dcyc = k + 1;
      end
      if (busy_a && wa_a) saw_acc = 1'b1;
      @(posedge clk);
      #1;
    end
    reg_write = 1'b0;
    check("busy_cycles", 32'(nb), 32'd33);
    check("done_pulses", 32'(nd), 32'd1);
    check("done_cycle", 32'(dcyc), 32'd33);
    check("acc_in_sweep", {31'b0, saw_acc}, 32'h0);
    rsel(9, 31);
    #1;
    check("clr9", rd_a[31:0], 32'h0);
    check("clr31", rd_a[63:32], 32'h0);
    rsel(4, 4);
    #1;
    check("held_wr4", rd_a[31:0], 32'h4444);
    for (int i = 0; i < 32; i++) begin
      rsel(5'(i), 5'(i));
      step();
    end

    set_wr(30, 32'h30, 4'b1111);
    step();
    set_wr(29, 32'h29, 4'b1111);
    step();
    reg_write = 1'b0;
    rsel(30, 29);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (9) step();
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy_a}, 32'h0);
    check("abort_r30", rd_a[31:0], 32'h0);
    check("abort_r29B", rd_b[63:32], 32'h0);
    done_in_rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done_a || done_b) done_in_rst = 1'b1;
      @(posedge clk);
      #1;
    end
    check("abort_nodone", {31'b0, done_in_rst}, 32'h0);
    reset = 1'b0;
    set_wr(3, 32'h1, 4'b1111);
    rsel(3, 30);
    #1;
    check("post_acc", {31'b0, wa_a}, 32'h1);
    step();
    reg_write = 1'b0;
    #1;
    check("post_r3", rd_a[31:0], 32'h1);
    check("post_r30", rd_a[63:32], 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
